pulse_stretcher: RTL

Converts single-cycle request pulses into clean multi-cycle output pulses of fixed length, separated by a guaranteed minimum low gap. It is the inverse of the single-pulse generator in the pushbutton path. Typical uses are driving LEDs, relays or slow external inputs from one-clock strobes. Requests arriving while a pulse is in progress are either queued (each request yields its own output pulse) or used to retrigger and extend the current pulse.

---
 rtl/pulse_stretcher_pkg.sv | 26 ++
 rtl/pulse_stretcher_cnt.sv | 38 +++
 rtl/pulse_stretcher.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pulse_stretcher_pkg.sv
// pulse_stretcher_pkg
// Shared definitions for the pulse stretcher: the FSM state encoding and
// helper functions that size the internal counters from the parameters.
// No ports; imported by the pulse_stretcher top module.
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_e;

    // The phase counter holds at most max(high, gap) - 1. Clamp the width
    // to one bit so a 1/1 configuration still gets a legal vector.
    function automatic int cntWidth(input int highCycles, input int gapCycles);
        int maxCycles;
        maxCycles = (highCycles > gapCycles) ? highCycles : gapCycles;
        return ($clog2(maxCycles) < 1) ? 1 : $clog2(maxCycles);
    endfunction

    // The pending counter has to represent 0..pendMax inclusive.
    function automatic int pendWidth(input int pendMax);
        return ($clog2(pendMax + 1) < 1) ? 1 : $clog2(pendMax + 1);
    endfunction

endpackage

// File: rtl/pulse_stretcher_cnt.sv
// pulse_stretcher_cnt
// Loadable down-counter with a zero flag. It times both the high phase and
// the gap phase of the stretcher.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset, clears the count
//   load_i     in   load load_val_i this cycle (wins over dec_i)
//   load_val_i in   W-bit value to load
//   dec_i      in   decrement by one; saturates at zero
//   zero_o     out  high while the count is zero
module pulse_stretcher_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // Load has priority. A decrement at zero is ignored, so the count can
    // never wrap around to its maximum.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// pulse_stretcher
// Turns one-clock request strobes into fixed-length output pulses separated
// by a minimum low gap. Requests during a pulse are either queued in a
// saturating pending counter or, in retrigger mode, extend the current pulse.
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset
//   ubsing  in   request strobe, one request per high cycle
//   retrig  in   1 = extend the pulse during HIGH, 0 = queue the request
//   ub      out  stretched pulse, registered, high only in HIGH
//   busy    out  registered, high in any state other than IDLE
//   pend    out  number of requests still waiting for service
//   ovf     out  sticky flag for a dropped request, cleared only by rst
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int HIGH_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int PEND_MAX    = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ubsing,
    input  logic                           retrig,
    output logic                           ub,
    output logic                           busy,
    output logic [pendWidth(PEND_MAX)-1:0] pend,
    output logic                           ovf
);

    localparam int CntW  = cntWidth(HIGH_CYCLES, GAP_CYCLES);
    localparam int PendW = pendWidth(PEND_MAX);

    localparam logic [CntW-1:0]  HighLoad = CntW'(HIGH_CYCLES - 1);
    localparam logic [CntW-1:0]  GapLoad  = CntW'(GAP_CYCLES - 1);
    localparam logic [PendW-1:0] PendFull = PendW'(PEND_MAX);

    state_e            state_q, state_d;
    logic [PendW-1:0]  pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              ub_q, busy_q;

    logic              cnt_load, cnt_dec, cnt_zero, enq;
    logic [CntW-1:0]   cnt_load_val;

    pulse_stretcher_cnt #(
        .W(CntW)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Next-state decode. A request that starts a pulse directly (from IDLE,
    // or at the end of an empty gap) is consumed, not queued. At the end of
    // a gap with work pending, a simultaneous request replaces the one being
    // consumed, so pend is left alone and no overflow can happen there.
    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        ovf_d        = ovf_q;
        cnt_load     = 1'b0;
        cnt_load_val = HighLoad;
        cnt_dec      = 1'b0;
        enq          = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ubsing) begin
                    state_d  = HIGH;
                    cnt_load = 1'b1;
                end
            end
            HIGH: begin
                if (retrig && ubsing) begin
                    cnt_load = 1'b1;
                end else begin
                    if (cnt_zero) begin
                        state_d      = GAP;
                        cnt_load     = 1'b1;
                        cnt_load_val = GapLoad;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                    enq = ubsing;
                end
            end
            GAP: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                    enq     = ubsing;
                end else if (pend_q != '0) begin
                    state_d  = HIGH;
                    cnt_load = 1'b1;
                    if (!ubsing) begin
                        pend_d = pend_q - PendW'(1);
                    end
                end else if (ubsing) begin
                    state_d  = HIGH;
                    cnt_load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Saturating enqueue; a request that finds the counter full is lost.
        if (enq) begin
            if (pend_q < PendFull) begin
                pend_d = pend_q + PendW'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    // ub and busy are registered from the next state, so they line up with
    // the state register and carry no combinational path from ubsing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            ub_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            ub_q    <= (state_d == HIGH);
            busy_q  <= (state_d != IDLE);
        end
    end

    assign ub   = ub_q;
    assign busy = busy_q;
    assign pend = pend_q;
    assign ovf  = ovf_q;

endmodule
